// File: rtl/sdram_req_bridge_pkg.sv
// Shared definitions for the SDRAM request bridge:
// FSM state encoding, byte-mask and timeout read-data constants.
package sdram_req_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // No bytes masked (reads always fetch the full word)
    localparam logic [1:0]  DM_NONE       = 2'b00;
    // Read data returned when the controller never answers
    localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

    // Controller masks are active high; bus selects are active high.
    function automatic logic [1:0] byte_mask(
        input logic       we,
        input logic [1:0] sel
    );
        return we ? ~sel : DM_NONE;
    endfunction

endpackage

// File: rtl/sdram_req_bridge.sv
// Strobe-bus to SDRAM-controller req/ack bridge with stall watchdog.
// Ports: bus_* (kernel strobe bus), sdr_* (controller level req/ack), init_done, busy, timeout_err.
module sdram_req_bridge
    import sdram_req_bridge_pkg::*;
#(
    parameter int AW      = 21,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bus_stb,
    input  logic          bus_we,
    input  logic [1:0]    bus_sel,
    input  logic [AW-1:0] bus_adr,
    input  logic [15:0]   bus_dat_i,
    output logic [15:0]   bus_dat_o,
    output logic          bus_ack,
    input  logic          init_done,
    output logic          sdr_wr_req,
    output logic          sdr_rd_req,
    input  logic          sdr_wr_ack,
    input  logic          sdr_rd_ack,
    output logic [AW:0]   sdr_addr,
    output logic [15:0]   sdr_wdata,
    input  logic [15:0]   sdr_rdata,
    output logic [1:0]    sdr_dm,
    output logic          busy,
    output logic          timeout_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT - 1);
    localparam bit            WD_EN    = (TIMEOUT > 0);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [15:0]   wdat_q, wdat_d;
    logic [1:0]    dm_q, dm_d;
    logic          we_q, we_d;
    logic          wr_req_q, wr_req_d;
    logic          rd_req_q, rd_req_d;
    logic          ack_q, ack_d;
    logic [15:0]   rdat_q, rdat_d;
    logic          terr_q, terr_d;

    logic ctrl_ack;
    logic wd_fire;

    // Only an ack of the kind we requested retires the request.
    assign ctrl_ack = we_q ? sdr_wr_ack : sdr_rd_ack;
    // Fires on the TIMEOUT-th cycle spent in REQ.
    assign wd_fire  = WD_EN && (cnt_q == CNT_FIRE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        dm_d     = dm_q;
        we_d     = we_q;
        wr_req_d = wr_req_q;
        rd_req_d = rd_req_q;
        ack_d    = ack_q;
        rdat_d   = rdat_q;
        terr_d   = terr_q;

        unique case (state_q)
            ST_IDLE: begin
                ack_d = 1'b0;
                if (bus_stb && init_done) begin
                    adr_d    = bus_adr;
                    wdat_d   = bus_dat_i;
                    we_d     = bus_we;
                    dm_d     = byte_mask(bus_we, bus_sel);
                    wr_req_d = bus_we;
                    rd_req_d = ~bus_we;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ctrl_ack) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    if (!we_q) begin
                        rdat_d = sdr_rdata;
                    end
                    ack_d   = bus_stb;
                    state_d = bus_stb ? ST_DONE : ST_DRAIN;
                end else if (wd_fire) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    terr_d   = 1'b1;
                    rdat_d   = TIMEOUT_RDATA;
                    ack_d    = bus_stb;
                    state_d  = bus_stb ? ST_DONE : ST_DRAIN;
                end else if (WD_EN && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                // Ack stays up until the master releases the strobe.
                if (!bus_stb) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            adr_q    <= '0;
            wdat_q   <= '0;
            dm_q     <= DM_NONE;
            we_q     <= 1'b0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            dm_q     <= dm_d;
            we_q     <= we_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            terr_q   <= terr_d;
        end
    end

    assign bus_dat_o   = rdat_q;
    assign bus_ack     = ack_q;
    assign sdr_wr_req  = wr_req_q;
    assign sdr_rd_req  = rd_req_q;
    assign sdr_addr    = {1'b0, adr_q};
    assign sdr_wdata   = wdat_q;
    assign sdr_dm      = dm_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Directed bench for sdram_req_bridge (AW=21, TIMEOUT=15).
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_sdram_req_bridge;

    localparam int AW = 21;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bus_stb;
    logic          bus_we;
    logic [1:0]    bus_sel;
    logic [AW-1:0] bus_adr;
    logic [15:0]   bus_dat_i;
    logic [15:0]   bus_dat_o;
    logic          bus_ack;
    logic          init_done;
    logic          sdr_wr_req;
    logic          sdr_rd_req;
    logic          sdr_wr_ack;
    logic          sdr_rd_ack;
    logic [AW:0]   sdr_addr;
    logic [15:0]   sdr_wdata;
    logic [15:0]   sdr_rdata;
    logic [1:0]    sdr_dm;
    logic          busy;
    logic          timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    sdram_req_bridge #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_stb     (bus_stb),
        .bus_we      (bus_we),
        .bus_sel     (bus_sel),
        .bus_adr     (bus_adr),
        .bus_dat_i   (bus_dat_i),
        .bus_dat_o   (bus_dat_o),
        .bus_ack     (bus_ack),
        .init_done   (init_done),
        .sdr_wr_req  (sdr_wr_req),
        .sdr_rd_req  (sdr_rd_req),
        .sdr_wr_ack  (sdr_wr_ack),
        .sdr_rd_ack  (sdr_rd_ack),
        .sdr_addr    (sdr_addr),
        .sdr_wdata   (sdr_wdata),
        .sdr_rdata   (sdr_rdata),
        .sdr_dm      (sdr_dm),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [15:0] stb_pat;
    logic [15:0] ack_pat;
    int          n_req, n_ack, n_hi;
    logic        pw, pa;

    initial begin
        rst_n      = 1'b0;
        bus_stb    = 1'b0;
        bus_we     = 1'b0;
        bus_sel    = 2'b00;
        bus_adr    = '0;
        bus_dat_i  = '0;
        init_done  = 1'b1;
        sdr_wr_ack = 1'b0;
        sdr_rd_ack = 1'b0;
        sdr_rdata  = '0;

        // reset state
        repeat (2) @(posedge clk);
        smp();
        check("rst_wr_req", sdr_wr_req, 0);
        check("rst_rd_req", sdr_rd_req, 0);
        check("rst_ack", bus_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_dat_o", bus_dat_o, 0);
        check("rst_terr", timeout_err, 0);
        step();
        rst_n = 1'b1;
        step();

        // write, ack in cycle 4
        bus_stb   = 1'b1;
        bus_we    = 1'b1;
        bus_adr   = 21'h012345;
        bus_dat_i = 16'hA5C3;
        bus_sel   = 2'b01;
        step();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) sdr_wr_ack = 1'b1;
            smp();
            check("wr_req_hi", sdr_wr_req, 1);
            check("wr_no_ack", bus_ack, 0);
            if (c == 1) begin
                check("wr_rd_req", sdr_rd_req, 0);
                check("wr_dm", sdr_dm, 2'b10);
                check("wr_addr", sdr_addr, 22'h012345);
                check("wr_wdata", sdr_wdata, 16'hA5C3);
                check("wr_busy", busy, 1);
            end
            step();
        end
        sdr_wr_ack = 1'b0;
        smp();
        check("wr_ack_c5", bus_ack, 1);
        check("wr_req_c5", sdr_wr_req, 0);
        bus_stb = 1'b0;
        step();
        smp();
        check("wr_ack_drop", bus_ack, 0);
        check("wr_idle", busy, 0);
        step();

        // read, stray write ack ignored
        bus_stb = 1'b1;
        bus_we  = 1'b0;
        bus_adr = 21'h1FFFFF;
        bus_sel = 2'b11;
        step();
        sdr_wr_ack = 1'b1;
        smp();
        check("rd_req_hi", sdr_rd_req, 1);
        check("rd_wr_req", sdr_wr_req, 0);
        check("rd_dm", sdr_dm, 2'b00);
        check("rd_addr", sdr_addr, 22'h1FFFFF);
        step();
        sdr_wr_ack = 1'b0;
        sdr_rd_ack = 1'b1;
        sdr_rdata  = 16'h1234;
        smp();
        check("rd_mismatch_ign", sdr_rd_req, 1);
        check("rd_no_ack", bus_ack, 0);
        step();
        sdr_rd_ack = 1'b0;
        sdr_rdata  = 16'h0000;
        smp();
        check("rd_ack", bus_ack, 1);
        check("rd_data", bus_dat_o, 16'h1234);
        check("rd_req_lo", sdr_rd_req, 0);
        bus_stb = 1'b0;
        step();
        smp();
        check("rd_ack_drop", bus_ack, 0);
        step();

        // abort: stb dropped cycle 2, ack cycle 6
        bus_stb   = 1'b1;
        bus_we    = 1'b1;
        bus_adr   = 21'h000100;
        bus_dat_i = 16'h0F0F;
        bus_sel   = 2'b11;
        step();
        smp();
        check("ab_req_c1", sdr_wr_req, 1);
        step();
        bus_stb = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            if (c == 6) sdr_wr_ack = 1'b1;
            smp();
            check("ab_req_held", sdr_wr_req, 1);
            check("ab_no_ack", bus_ack, 0);
            step();
        end
        sdr_wr_ack = 1'b0;
        smp();
        check("ab_req_lo", sdr_wr_req, 0);
        check("ab_no_ack_c7", bus_ack, 0);
        check("ab_busy_c7", busy, 1);
        step();
        smp();
        check("ab_busy_c8", busy, 0);
        check("ab_no_ack_c8", bus_ack, 0);
        step();

        // watchdog: no ctrl ack
        bus_stb = 1'b1;
        bus_we  = 1'b0;
        bus_adr = 21'h000AAA;
        step();
        for (int c = 1; c <= TO; c++) begin
            smp();
            check("to_req_hi", sdr_rd_req, 1);
            if (c == TO) check("to_terr_pre", timeout_err, 0);
            step();
        end
        smp();
        check("to_req_lo", sdr_rd_req, 0);
        check("to_terr", timeout_err, 1);
        check("to_ack", bus_ack, 1);
        check("to_data", bus_dat_o, 16'hFFFF);
        sdr_rd_ack = 1'b1;
        sdr_rdata  = 16'h5555;
        step();
        sdr_rd_ack = 1'b0;
        sdr_rdata  = 16'h0000;
        smp();
        check("to_late_ack_ign", bus_dat_o, 16'hFFFF);
        check("to_ack_hold", bus_ack, 1);
        bus_stb = 1'b0;
        step();
        smp();
        check("to_ack_drop", bus_ack, 0);
        check("to_idle", busy, 0);
        check("to_terr_sticky", timeout_err, 1);
        step();

        // back-to-back: stb high, low one cycle, high again
        bus_we    = 1'b1;
        bus_adr   = 21'h000042;
        bus_dat_i = 16'h4242;
        bus_sel   = 2'b11;
        stb_pat   = 16'h0077;
        ack_pat   = 16'h0022;
        n_req = 0;
        n_ack = 0;
        n_hi  = 0;
        pw    = 1'b0;
        pa    = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus_stb    = stb_pat[c];
            sdr_wr_ack = ack_pat[c];
            smp();
            if (sdr_wr_req && !pw) n_req++;
            if (bus_ack && !pa) n_ack++;
            if (bus_ack) n_hi++;
            pw = sdr_wr_req;
            pa = bus_ack;
            step();
        end
        bus_stb    = 1'b0;
        sdr_wr_ack = 1'b0;
        check("b2b_req_pulses", n_req, 2);
        check("b2b_ack_pulses", n_ack, 2);
        check("b2b_ack_cycles", n_hi, 4);
        step();

        // reset mid-REQ, then held off by init_done
        bus_stb = 1'b1;
        bus_we  = 1'b1;
        bus_adr = 21'h000777;
        step();
        step();
        smp();
        check("rr_req_pre", sdr_wr_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_wr_req", sdr_wr_req, 0);
        check("rr_busy", busy, 0);
        check("rr_addr", sdr_addr, 0);
        check("rr_wdata", sdr_wdata, 0);
        check("rr_dat_o", bus_dat_o, 0);
        check("rr_terr", timeout_err, 0);
        init_done = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            smp();
            check("hold_no_req", sdr_wr_req, 0);
            check("hold_idle", busy, 0);
            step();
        end
        init_done = 1'b1;
        step();
        smp();
        check("init_req", sdr_wr_req, 1);
        sdr_wr_ack = 1'b1;
        step();
        sdr_wr_ack = 1'b0;
        bus_stb    = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
